wave_analyzer: RTL

Measures a sampled periodic waveform, such as the output of the team's sawtooth generator, and reports its period in clock cycles plus its per-period maximum, minimum and peak-to-peak amplitude. It sits on the consumer side of the generator's 16-bit sample bus. It gives the test and display logic a self-check of generator settings: for a sawtooth, expected period = (amplitude+1)·(prescaler+1) clocks.

---
 rtl/wave_pkg.sv | 27 ++
 rtl/wave_edge_detect.sv | 48 ++++
 rtl/wave_analyzer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/wave_pkg.sv
// Shared types and saturating helpers for the waveform analyzer.
package wave_pkg;

    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        SEEK_LOW,
        SEEK_HIGH,
        RUN_LOW,
        RUN_HIGH
    } state_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] ceil);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, ceil}) ? ceil : s[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/wave_edge_detect.sv
// Hysteresis crossing detector: latched thresholds, armed flag, arm/trigger strobes.
module wave_edge_detect import wave_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned HYST   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              latch,
    input  logic              en,
    input  logic [DATA_W-1:0] threshold,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              arm_c,
    output logic              trig_c
);

    localparam logic [31:0] DATA_MAX = 32'((64'd1 << DATA_W) - 64'd1);

    logic [DATA_W-1:0] thr_lo;
    logic [DATA_W-1:0] thr_hi;
    logic              armed;

    assign arm_c  = en && sample_valid && (sample <= thr_lo);
    assign trig_c = en && sample_valid && armed && (sample >= thr_hi);

    // Clear wins over a same-cycle arm so a timed-out run restarts disarmed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            thr_lo <= '0;
            thr_hi <= '0;
            armed  <= 1'b0;
        end else begin
            if (latch) begin
                thr_lo <= DATA_W'(sat_sub(32'(threshold), 32'(HYST)));
                thr_hi <= DATA_W'(sat_add(32'(threshold), 32'(HYST), DATA_MAX));
            end
            if (clr) begin
                armed <= 1'b0;
            end else if (trig_c) begin
                armed <= 1'b0;
            end else if (arm_c) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_analyzer.sv
// Period and per-period max/min/peak-to-peak measurement of a sampled periodic waveform.
module wave_analyzer import wave_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned HYST   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] threshold,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              meas_valid,
    output logic [CNT_W-1:0]  period,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] amplitude,
    output logic              timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] max_trk;
    logic [DATA_W-1:0] min_trk;

    logic arm_c;
    logic trig_c;
    logic in_run_c;
    logic pub_c;
    logic sat_c;
    logic edge_clr_c;

    assign in_run_c   = (state == RUN_LOW) || (state == RUN_HIGH);
    assign pub_c      = (state == RUN_HIGH) && trig_c;
    assign sat_c      = in_run_c && !pub_c && (cnt == CNT_MAX);
    assign edge_clr_c = (state == IDLE) || sat_c;

    wave_edge_detect #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_edge (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (edge_clr_c),
        .latch        ((state == IDLE) && ena),
        .en           (state != IDLE),
        .threshold    (threshold),
        .sample_valid (sample_valid),
        .sample       (sample),
        .arm_c        (arm_c),
        .trig_c       (trig_c)
    );

    // FSM, period counter, trackers and published results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            max_trk    <= '0;
            min_trk    <= '0;
            meas_valid <= 1'b0;
            period     <= '0;
            max_val    <= '0;
            min_val    <= '0;
            amplitude  <= '0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!ena) begin
                state   <= IDLE;
                cnt     <= '0;
                max_trk <= '0;
                min_trk <= '0;
                timeout <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: state <= SEEK_LOW;
                    SEEK_LOW: begin
                        if (arm_c) state <= SEEK_HIGH;
                    end
                    SEEK_HIGH: begin
                        if (trig_c) begin
                            state   <= RUN_LOW;
                            cnt     <= CNT_ONE;
                            max_trk <= sample;
                            min_trk <= sample;
                        end
                    end
                    RUN_LOW, RUN_HIGH: begin
                        if (pub_c) begin
                            meas_valid <= 1'b1;
                            period     <= cnt;
                            max_val    <= max_trk;
                            min_val    <= min_trk;
                            amplitude  <= max_trk - min_trk;
                            cnt        <= CNT_ONE;
                            max_trk    <= sample;
                            min_trk    <= sample;
                            state      <= RUN_LOW;
                        end else if (sat_c) begin
                            timeout <= 1'b1;
                            state   <= SEEK_LOW;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                            if (sample_valid) begin
                                if (sample > max_trk) max_trk <= sample;
                                if (sample < min_trk) min_trk <= sample;
                            end
                            if ((state == RUN_LOW) && arm_c) state <= RUN_HIGH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
